main_memory_ctrl: RTL and testbench

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

---
 rtl/main_memory_ctrl_pkg.sv | 22 ++
 rtl/main_memory_ctrl_mem_array.sv | 29 ++
 rtl/main_memory_ctrl.sv | 107 ++++++++++
 tb/tb_main_memory_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared memory-system definitions: FSM encoding, operation type and default geometry/latency
// used by both the main memory controller and the cache controller.
package main_memory_ctrl_pkg;

    localparam int RISC_DATA_W = 32;
    localparam int MAIN_DATA_W = 128;
    localparam int MEM_DEPTH   = 256;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/main_memory_ctrl_mem_array.sv
// Block storage: depth x block-width array with a registered read port and a
// single-word lane write. Contents are never reset.
module mem_array
    import main_memory_ctrl_pkg::*;
#(
    parameter int WORD_W  = RISC_DATA_W,
    parameter int BLOCK_W = MAIN_DATA_W,
    parameter int DEPTH   = MEM_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int LANE_W = $clog2(BLOCK_W / WORD_W)
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    input  logic               we,
    input  logic [LANE_W-1:0]  lane,
    input  logic [WORD_W-1:0]  wd,
    output logic [BLOCK_W-1:0] rd
);

    logic [BLOCK_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr][lane*WORD_W +: WORD_W] <= wd;
        end
        rd <= mem_reg[addr];
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Main memory controller: accepts one block read or word write at a time, completes it
// LATENCY cycles after accept with a one-cycle mem_done, and aborts if the request drops.
module main_memory_ctrl
    import main_memory_ctrl_pkg::*;
#(
    parameter int RISC_data = RISC_DATA_W,
    parameter int main_data = MAIN_DATA_W,
    parameter int mem_depth = MEM_DEPTH,
    parameter int LATENCY   = MEM_LATENCY
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [7:0]           A,
    input  logic [1:0]           WO,
    input  logic                 mem_RE,
    input  logic                 mem_WE,
    input  logic [RISC_data-1:0] WD,
    output logic [main_data-1:0] RD,
    output logic                 mem_done,
    output logic                 busy
);

    localparam int AW = $clog2(mem_depth);

    mem_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    mem_op_t              op_reg;
    logic [7:0]           addr_reg;
    logic [1:0]           wo_reg;
    logic [RISC_data-1:0] wd_reg;
    logic                 accept;
    logic                 commit;
    logic                 op_line;
    logic [main_data-1:0] arr_rd;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        op_line    = (op_reg == OP_WRITE) ? mem_WE : mem_RE;
        case (state_reg)
            IDLE: begin
                if (mem_WE || mem_RE) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // A dropped request line wins over completion: nothing commits.
                if (!op_line) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_READ;
            addr_reg  <= '0;
            wo_reg    <= '0;
            wd_reg    <= '0;
            RD        <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_reg   <= mem_WE ? OP_WRITE : OP_READ;
                addr_reg <= A;
                wo_reg   <= WO;
                wd_reg   <= WD;
            end
            // The array read port tracks addr_reg throughout ACCESS, so arr_rd is settled here.
            if (commit && op_reg == OP_READ) begin
                RD <= arr_rd;
            end
        end
    end

    assign mem_done = (state_reg == DONE);
    assign busy     = (state_reg != IDLE);

    mem_array #(
        .WORD_W  (RISC_data),
        .BLOCK_W (main_data),
        .DEPTH   (mem_depth)
    ) u_mem_array (
        .clk  (clk),
        .addr (addr_reg[AW-1:0]),
        .we   (commit && op_reg == OP_WRITE),
        .lane (wo_reg),
        .wd   (wd_reg),
        .rd   (arr_rd)
    );

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: expected read blocks are queued at request time
// and popped when mem_done is observed; a shadow model tracks every committed write.
module tb_main_memory_ctrl;

    logic         clk = 1'b0;
    logic         RST = 1'b0;
    logic [7:0]   A = '0;
    logic [1:0]   WO = '0;
    logic         mem_RE = 1'b0;
    logic         mem_WE = 1'b0;
    logic [31:0]  WD = '0;
    logic [127:0] RD;
    logic         mem_done;
    logic         busy;

    main_memory_ctrl dut (
        .clk      (clk),
        .RST      (RST),
        .A        (A),
        .WO       (WO),
        .mem_RE   (mem_RE),
        .mem_WE   (mem_WE),
        .WD       (WD),
        .RD       (RD),
        .mem_done (mem_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int           n_total = 0;
    int           n_bad = 0;
    logic [127:0] model [256];
    logic [127:0] exp_q [$];
    logic [127:0] last_rd = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts posedges until mem_done is seen; 20 means it never came.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (mem_done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    // One full transaction; address/offset/data are disturbed right after accept.
    task automatic do_txn(input logic re, input logic we, input logic [7:0] a,
                          input logic [1:0] wo, input logic [31:0] wd);
        int           cyc;
        logic [127:0] exp;
        if (we) model[a][wo*32 +: 32] = wd;
        else    exp_q.push_back(model[a]);
        mem_RE = re;
        mem_WE = we;
        A      = a;
        WO     = wo;
        WD     = wd;
        tick();
        check("busy_after_accept", busy, 1'b1);
        A  = a + 8'd1;
        WO = wo + 2'd1;
        WD = ~wd;
        wait_done(cyc);
        check("latency", cyc, 4);
        if (we) begin
            check("rd_hold_on_write", RD, last_rd);
        end else begin
            exp = exp_q.pop_front();
            check("rd_block", RD, exp);
            last_rd = exp;
        end
        $display("txn %s a=%h wo=%0d wd=%h lat=%0d rd=%h", we ? "WR" : "RD", a, wo, wd, cyc, RD);
        mem_RE = 1'b0;
        mem_WE = 1'b0;
        tick();
        check("done_one_cycle", mem_done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        int           cyc;
        int           gap;
        logic         seen;
        logic [127:0] tmp;
        logic [7:0]   blks [4];
        blks[0] = 8'h07; blks[1] = 8'h08; blks[2] = 8'h20; blks[3] = 8'h30;

        // Reset state, with a request held that must be ignored.
        mem_RE = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", mem_done, 1'b0);
        check("rst_rd", RD, 128'h0);
        mem_RE = 1'b0;
        RST = 1'b1;
        tick();

        for (int b = 0; b < 4; b++)
            for (int l = 0; l < 4; l++)
                do_txn(1'b0, 1'b1, blks[b], 2'(l), $urandom);

        for (int l = 0; l < 4; l++)
            do_txn(1'b0, 1'b1, 8'h15, 2'(l), 32'h11111111 * (l + 1));
        do_txn(1'b1, 1'b0, 8'h15, 2'd0, 32'h0);
        check("blk15_literal", RD, 128'h44444444_33333333_22222222_11111111);

        // Both requests high: write wins, RD untouched.
        do_txn(1'b1, 1'b1, 8'h20, 2'd2, 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 8'h20, 2'd0, 32'h0);
        tmp = RD;
        check("lane2_deadbeef", tmp[95:64], 32'hDEADBEEF);

        // A moves from 0x07 to 0x08 right after accept; block 0x07 must come back.
        do_txn(1'b1, 1'b0, 8'h07, 2'd0, 32'h0);
        check("a_change_ignored", RD, model[8'h07]);

        // Read held through DONE: one pulse, IDLE, re-accept, next pulse after 5 low cycles.
        mem_RE = 1'b1;
        A = 8'h15;
        tick();
        wait_done(cyc);
        check("held_lat1", cyc, 4);
        gap = 0;
        tick();
        while (mem_done !== 1'b1 && gap < 20) begin
            gap++;
            tick();
        end
        check("held_gap_low_cycles", gap, 5);
        check("held_rd", RD, model[8'h15]);
        $display("txn RD-held a=15 lat=%0d gap=%0d rd=%h", cyc, gap, RD);
        mem_RE = 1'b0;
        last_rd = model[8'h15];
        tick();
        check("held_done_drop", mem_done, 1'b0);

        // Abort: drop mem_WE after two ACCESS cycles.
        mem_WE = 1'b1;
        A = 8'h30;
        WO = 2'd1;
        WD = ~model[8'h30][63:32];
        tick();
        tick();
        tick();
        mem_WE = 1'b0;
        seen = 1'b0;
        tick();
        check("abort_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (mem_done === 1'b1) seen = 1'b1;
            tick();
        end
        check("abort_no_done", seen, 1'b0);
        $display("txn WR-abort a=30 wo=1");
        do_txn(1'b1, 1'b0, 8'h30, 2'd0, 32'h0);

        // Asynchronous reset in the middle of a write's ACCESS.
        mem_WE = 1'b1;
        A = 8'h30;
        WO = 2'd0;
        WD = ~model[8'h30][31:0];
        tick();
        tick();
        #2 RST = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", mem_done, 1'b0);
        check("midrst_rd", RD, 128'h0);
        mem_WE = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        last_rd = '0;
        $display("txn WR-reset a=30 wo=0");
        tick();
        do_txn(1'b1, 1'b0, 8'h30, 2'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
